// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle restoring divider, one quotient bit per clock
// Optional two's-complement mode: SEQ_DIVIDER_SIGNED_EN
module seq_divider #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [1:0]    state;
  logic [N-1:0]  q_sh;
  logic [N-1:0]  dvsr;
  logic [N-1:0]  rem_p;
  logic [CW-1:0] cnt;

  logic [N:0]    r_shift;
  logic [N:0]    r_diff;
  logic          fits;
  logic [N-1:0]  r_keep;
  logic [N-1:0]  q_next;
  logic          accept;
  logic [N-1:0]  mag_a;
  logic [N-1:0]  mag_b;
  logic [N-1:0]  res_q;
  logic [N-1:0]  res_r;

  assign busy   = (state == S_RUN);
  assign done   = (state == S_DONE);
  assign accept = start && ((state == S_IDLE) || (state == S_DONE));

  // The restored remainder is always below the divisor, so N bits of storage
  // suffice; the sign bit of the N+1-bit trial difference is the borrow.
  assign r_shift = {rem_p, q_sh[N-1]};
  assign r_diff  = r_shift - {1'b0, dvsr};
  assign fits    = ~r_diff[N];
  assign r_keep  = fits ? r_diff[N-1:0] : r_shift[N-1:0];
  assign q_next  = {q_sh[N-2:0], fits};

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic neg_q;
  logic neg_r;

  assign mag_a = dividend[N-1] ? (~dividend + 1'b1) : dividend;
  assign mag_b = divisor[N-1]  ? (~divisor + 1'b1)  : divisor;
  assign res_q = neg_q ? (~q_next + 1'b1) : q_next;
  assign res_r = neg_r ? (~r_keep + 1'b1) : r_keep;
`else
  assign mag_a = dividend;
  assign mag_b = divisor;
  assign res_q = q_next;
  assign res_r = r_keep;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      q_sh        <= '0;
      dvsr        <= '0;
      rem_p       <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            if (divisor == '0) begin
              state       <= S_DONE;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state <= S_RUN;
              q_sh  <= mag_a;
              dvsr  <= mag_b;
              rem_p <= '0;
              cnt   <= '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
              neg_q <= dividend[N-1] ^ divisor[N-1];
              neg_r <= dividend[N-1];
`endif
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          q_sh  <= q_next;
          rem_p <= r_keep;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            state       <= S_DONE;
            quotient    <= res_q;
            remainder   <= res_r;
            div_by_zero <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
